// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU constants and the divider FSM state encoding.
package alu_pkg;

   localparam int XLEN      = 32;
   localparam int DIV_ITERS = 32;
   localparam int CNT_W     = 6;

   // Iteration counter preload: counts DIV_ITERS-1 down to 0, one step per RUN edge.
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_ITERS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_e;

endpackage

// File: rtl/add32.sv
// add32: plain 32-bit ripple adder with carry-in and carry-out.
// Subtraction is done by the caller inverting y and setting cin.
module add32
   import alu_pkg::*;
(
   input  logic [XLEN-1:0] x,
   input  logic [XLEN-1:0] y,
   input  logic            cin,
   output logic [XLEN-1:0] sum,
   output logic            cout
);

   // Full-width add; the extra top bit becomes the carry-out.
   always_comb begin
      {cout, sum} = {1'b0, x} + {1'b0, y} + {{XLEN{1'b0}}, cin};
   end

endmodule

// File: rtl/div32.sv
// div32: 32-bit radix-2 restoring divider with a fixed 33-cycle latency
// (32 RUN iterations plus one FIX cycle).
// Optional feature: define DIV32_SIGNED_EN to honour is_signed (DIV/REM,
// truncating, remainder takes the dividend's sign). Without it every
// operation is unsigned (DIVU/REMU) and is_signed is ignored.
module div32
   import alu_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            is_signed,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] q,
   output logic [XLEN-1:0] r,
   output logic            dz
);

   div_state_e       state_q;
   div_state_e       state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [XLEN-1:0]  rem_q;
   logic [XLEN-1:0]  quo_q;
   logic [XLEN-1:0]  dvs_q;
   logic             zero_q;
   logic             accept;
   logic [XLEN-1:0]  a_mag;
   logic [XLEN-1:0]  b_mag;
   logic [XLEN-1:0]  rem_sh;
   logic [XLEN-1:0]  add_x;
   logic [XLEN-1:0]  add_y;
   logic             add_cin;
   logic [XLEN-1:0]  add_sum;
   logic             add_cout;
   logic             commit;
   logic [XLEN-1:0]  fix_q;
   logic [XLEN-1:0]  fix_r;

`ifdef DIV32_SIGNED_EN
   logic             a_neg;
   logic             b_neg;
   logic             neg_quo_q;
   logic             neg_rem_q;

   function automatic logic [XLEN-1:0] neg32(input logic [XLEN-1:0] x);
      return ~x + {{(XLEN-1){1'b0}}, 1'b1};
   endfunction

   // Operand magnitudes: only negative values in signed mode get negated.
   assign a_neg = is_signed & a[XLEN-1];
   assign b_neg = is_signed & b[XLEN-1];
   assign a_mag = a_neg ? neg32(a) : a;
   assign b_mag = b_neg ? neg32(b) : b;
`else
   logic             is_signed_unused;

   // Unsigned-only build: operands are used as-is.
   assign a_mag            = a;
   assign b_mag            = b;
   assign is_signed_unused = is_signed;
`endif

   // A new divide is taken only when no operation is in flight.
   assign accept = start & ~busy;

   // State register; reset abandons any operation in progress.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic and status outputs.
   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) state_d = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (cnt_q == '0) state_d = FIX;
         end
         FIX: begin
            busy    = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = start ? RUN : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Shared adder operands: trial subtract in RUN, quotient negation in FIX.
   always_comb begin
      rem_sh  = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
      add_x   = rem_sh;
      add_y   = ~dvs_q;
      add_cin = 1'b1;
`ifdef DIV32_SIGNED_EN
      if (state_q == FIX) begin
         add_x = ~quo_q;
         add_y = '0;
      end
`endif
   end

   add32 u_add32 (
      .x    (add_x),
      .y    (add_y),
      .cin  (add_cin),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // The shifted remainder is really 33 bits wide; if its dropped MSB was set
   // it exceeds any 32-bit divisor, so the trial must be committed regardless
   // of carry-out (only reachable for divisors at or above 2^31).
   assign commit = add_cout | rem_q[XLEN-1];

   // Final result: sign correction and the divide-by-zero quotient override.
   always_comb begin
      fix_q = quo_q;
      fix_r = rem_q;
`ifdef DIV32_SIGNED_EN
      if (neg_quo_q) fix_q = add_sum;
      if (neg_rem_q) fix_r = neg32(rem_q);
`endif
      if (zero_q) fix_q = '1;
   end

   // Iteration datapath: operand load on accept, one restoring step per RUN edge.
   always_ff @(posedge clk) begin
      if (accept) begin
         rem_q  <= '0;
         quo_q  <= a_mag;
         dvs_q  <= b_mag;
         zero_q <= (b == '0);
`ifdef DIV32_SIGNED_EN
         neg_quo_q <= a_neg ^ b_neg;
         neg_rem_q <= a_neg;
`endif
      end else if (state_q == RUN) begin
         rem_q <= commit ? add_sum : rem_sh;
         quo_q <= {quo_q[XLEN-2:0], commit};
      end
   end

   // Iteration counter and the architecturally visible result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         q     <= '0;
         r     <= '0;
         dz    <= 1'b0;
      end else begin
         if (accept)
            cnt_q <= CNT_LOAD;
         else if (state_q == RUN && cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
         if (state_q == FIX) begin
            q  <= fix_q;
            r  <= fix_r;
            dz <= zero_q;
         end
      end
   end

endmodule

// File: tb/tb_div32.sv
// tb_div32: randomized and directed scoreboard bench for div32.
// Expected results come from plain integer division in the bench.
module tb_div32;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        is_signed;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] q;
   logic [31:0] r;
   logic        dz;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
      int          cyc;
   } exp_t;

   exp_t sb_q[$];
   int   cyc    = 0;
   int   n_vec  = 0;
   int   n_err  = 0;

   div32 dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .is_signed (is_signed),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .q         (q),
      .r         (r),
      .dz        (dz)
   );

   always #5 clk = ~clk;

   // Edge counter: after rising edge n, cyc == n.
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: DIV/REM/DIVU/REMU semantics with wide integer arithmetic.
   function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
      exp_t   e;
      logic   sgn;
      longint sx, sy;
      sgn = s;
`ifndef DIV32_SIGNED_EN
      sgn = 1'b0;
`endif
      e.cyc = 0;
      if (y == 32'd0) begin
         e.q  = 32'hFFFF_FFFF;
         e.r  = x;
         e.dz = 1'b1;
      end else begin
         if (sgn) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
         end else begin
            sx = longint'({32'd0, x});
            sy = longint'({32'd0, y});
         end
         e.q  = 32'(sx / sy);
         e.r  = 32'(sx % sy);
         e.dz = 1'b0;
      end
      return e;
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && done) begin
         if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL spurious_done: got done=1, expected no done (cycle %0d)", cyc);
         end else begin
            e = sb_q.pop_front();
            chk("q", q, e.q);
            chk("r", r, e.r);
            chk("dz", {31'd0, dz}, {31'd0, e.dz});
            chk("done_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive a start for one edge; optionally record the expected result.
   task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic s, input bit push);
      exp_t e;
      a         = x;
      b         = y;
      is_signed = s;
      start     = 1'b1;
      if (push) begin
         e     = model(x, y, s);
         e.cyc = cyc + 1 + 33;
         sb_q.push_back(e);
      end
      tick();
      start     = 1'b0;
      a         = $urandom;
      b         = $urandom;
      is_signed = 1'(($urandom));
   endtask

   // Full operation; returns just after edge k+33 with the DUT in DONE.
   task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic s);
      issue(x, y, s, 1'b1);
      @(negedge clk);
      chk("busy_run", {31'd0, busy}, 32'd1);
      repeat (32) tick();
      @(negedge clk);
      chk("busy_fix", {31'd0, busy}, 32'd1);
      tick();
   endtask

   function automatic logic [31:0] pick();
      logic [31:0] v;
      case ($urandom_range(0, 7))
         0:       v = 32'd0;
         1:       v = 32'hFFFF_FFFF;
         2:       v = 32'h8000_0000;
         3:       v = $urandom_range(1, 20);
         4:       v = 32'h7FFF_FFFF;
         default: v = $urandom;
      endcase
      return v;
   endfunction

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      is_signed = 1'b0;
      a         = 32'd0;
      b         = 32'd0;
      repeat (3) tick();
      @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_q", q, 32'd0);
      chk("rst_r", r, 32'd0);
      chk("rst_dz", {31'd0, dz}, 32'd0);
      tick();
      rst = 1'b0;
      tick();

      // Directed corner cases, issued back-to-back from DONE.
      run_op(32'd100, 32'd7, 1'b0);
      run_op(32'd5, 32'd0, 1'b0);
      run_op(32'd5, 32'd0, 1'b1);
      run_op(32'hFFFF_FFF9, 32'd2, 1'b1);
      run_op(32'hFFFF_FFF9, 32'd2, 1'b0);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      run_op(32'hFFFF_FFFB, 32'd0, 1'b1);
      run_op(32'hFFFF_FFFF, 32'h8000_0001, 1'b0);

      // A start while busy must be ignored.
      issue(32'd1000, 32'd33, 1'b0, 1'b1);
      repeat (4) tick();
      a         = 32'd9;
      b         = 32'd3;
      is_signed = 1'b0;
      start     = 1'b1;
      tick();
      start = 1'b0;
      repeat (28) tick();

      // Reset mid-operation: no done pulse, outputs cleared.
      tick();
      issue(32'd12345, 32'd67, 1'b0, 1'b0);
      repeat (9) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_q", q, 32'd0);
      chk("abort_r", r, 32'd0);
      chk("abort_dz", {31'd0, dz}, 32'd0);
      tick();
      @(negedge clk);
      chk("abort_busy2", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      repeat (30) tick();
      run_op(32'd77, 32'd5, 1'b0);

      // Randomized operations.
      for (int i = 0; i < 40; i++) begin
         run_op(pick(), pick(), 1'(($urandom)));
      end

      repeat (3) tick();
      for (int i = 0; i < 100 && sb_q.size() != 0; i++) tick();
      chk("pending_results", sb_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
